// File: rtl/cpu_pkg.sv
// cpu_pkg
//  Shared definitions for the fetch front end.
//  - Bit positions of the instruction fields (opcode, rs, rt, rd, shamt,
//    funct, imm16, jidx).
//  - NOP word, used as the contents of empty instruction buffer slots.
//  - Fetch FSM state encoding.
//  - Default reset PC and the sequential PC increment helper.
package cpu_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_MSB = 10;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int JIDX_MSB  = 25;
   localparam int JIDX_LSB  = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_REQ     = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_t;

   // Sequential word step; wraps FFFF_FFFC -> 0000_0000 naturally.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo
//  Small circular buffer of fetched {pc, instr} entries.
//  Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one entry (ignored when full and not popping)
//   pop               drop the head entry (ignored when empty)
//   flush             empty the buffer; wins over push, pop is irrelevant
//   head_data         entry at the head (combinational)
//   count             number of valid entries
//   full, empty       count==DEPTH / count==0
module instr_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1))
         return '0;
      return p + 1'b1;
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   // A full buffer can still take a push when the head leaves in the same cycle.
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   // Storage is cleared on reset so the head reads as NOP with a zero PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= {{(WIDTH - 32){1'b0}}, NOP_WORD};
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//  Fetch stage: owns the PC, issues one word request at a time to instruction
//  memory, buffers returned words and presents the head split into fields.
//  Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/imem_addr       request and word address, held until imem_ack
//   imem_ack/imem_rdata      request accepted, data valid this cycle
//   redirect/redirect_pc     flush and refetch from redirect_pc (low bits 0)
//   out_valid/out_ready      head handshake
//   out_pc, out_instr        head PC and word
//   out_op..out_jidx         head instruction fields
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [5:0]  out_op,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_shamt,
   output logic [5:0]  out_funct,
   output logic [15:0] out_imm16,
   output logic [25:0] out_jidx
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t     state;
   fetch_state_t     next_state;
   logic [31:0]      fetch_pc;
   logic [31:0]      fetch_pc_next;
   logic [31:0]      req_addr;
   logic [31:0]      redirect_target;
   logic             push;
   logic             pop;
   logic             load_addr;
   logic [63:0]      head_data;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after_push;
   logic             full;
   logic             empty;
   logic [31:0]      head_instr;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({fetch_pc, imem_rdata}),
      .pop       (pop),
      .flush     (redirect),
      .head_data (head_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
   assign pop              = out_valid && out_ready;
   assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);

   // Next state, PC and push decision. load_addr marks a new request being
   // issued next cycle; its address is captured separately so a redirect
   // cannot disturb the address of a request still waiting for its ack.
   always_comb begin
      next_state    = state;
      fetch_pc_next = fetch_pc;
      push          = 1'b0;
      load_addr     = 1'b0;
      unique case (state)
         FETCH_IDLE: begin
            if (!redirect && !full) begin
               next_state = FETCH_REQ;
               load_addr  = 1'b1;
            end
         end
         FETCH_REQ: begin
            if (redirect) begin
               next_state = imem_ack ? FETCH_IDLE : FETCH_DISCARD;
            end else if (imem_ack) begin
               push          = 1'b1;
               fetch_pc_next = pc_inc(fetch_pc);
               if (count_after_push < CNT_W'(DEPTH))
                  load_addr = 1'b1;
               else
                  next_state = FETCH_IDLE;
            end
         end
         FETCH_DISCARD: begin
            if (imem_ack)
               next_state = FETCH_IDLE;
         end
         default: next_state = FETCH_IDLE;
      endcase
      if (redirect)
         fetch_pc_next = redirect_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= next_state;
         fetch_pc <= fetch_pc_next;
         if (load_addr)
            req_addr <= fetch_pc_next;
      end
   end

   assign imem_req  = (state != FETCH_IDLE);
   assign imem_addr = req_addr;

   // Head fields read as zero whenever nothing valid is presented.
   assign out_valid  = !empty;
   assign out_pc     = out_valid ? head_data[63:32] : 32'h0;
   assign head_instr = out_valid ? head_data[31:0]  : 32'h0;
   assign out_instr  = head_instr;
   assign out_op     = head_instr[OP_MSB:OP_LSB];
   assign out_rs     = head_instr[RS_MSB:RS_LSB];
   assign out_rt     = head_instr[RT_MSB:RT_LSB];
   assign out_rd     = head_instr[RD_MSB:RD_LSB];
   assign out_shamt  = head_instr[SHAMT_MSB:SHAMT_LSB];
   assign out_funct  = head_instr[FUNCT_MSB:FUNCT_LSB];
   assign out_imm16  = head_instr[IMM_MSB:IMM_LSB];
   assign out_jidx   = head_instr[JIDX_MSB:JIDX_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//  Directed bench for instr_fetch_unit. A memory model answers requests after
//  a programmable number of wait cycles and returns a word derived from the
//  address. Stimulus pushes the expected {pc, instr} stream into a queue; a
//  monitor pops and compares on every head handshake.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [5:0]  out_op;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm16;
   logic [25:0] out_jidx;

   int          checks   = 0;
   int          failures = 0;
   int          ack_delay = 0;
   int          wait_cnt;
   logic [63:0] sb_q [$];
   logic [63:0] mon_exp;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_op      (out_op),
      .out_rs      (out_rs),
      .out_rt      (out_rt),
      .out_rd      (out_rd),
      .out_shamt   (out_shamt),
      .out_funct   (out_funct),
      .out_imm16   (out_imm16),
      .out_jidx    (out_jidx)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200)
         return 32'h3C01_8001;
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory model: ack after ack_delay wait cycles of a held request.
   assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
   assign imem_rdata = mem_word(imem_addr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= 0;
      else if (!imem_req || imem_ack)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic redir,
                                input logic [31:0] rpc);
      out_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectWord(input logic [31:0] pc);
      sb_q.push_back({pc, mem_word(pc)});
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      sb_q.delete();
      tick();
      tick();
   endtask

   // Consume until every expected entry has been seen, then stop accepting.
   task automatic drainQueue(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 80 && sb_q.size() != 0; i++)
         tick();
      out_ready = 1'b0;
      checkOutput(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // Scoreboard monitor: samples each handshake half a cycle before its edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected actual_pc=%h expected=none", out_pc);
         end else begin
            mon_exp = sb_q.pop_front();
            checkOutput("sb_pc", out_pc, mon_exp[63:32]);
            checkOutput("sb_instr", out_instr, mon_exp[31:0]);
            checkOutput("sb_fields", {out_op, out_rs, out_rt, out_rd, out_shamt, out_funct},
                        mon_exp[31:0]);
            checkOutput("sb_imm16", {16'h0, out_imm16}, {16'h0, mon_exp[15:0]});
            checkOutput("sb_jidx", {6'h0, out_jidx}, {6'h0, mon_exp[25:0]});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);

      // Reset state and zero-wait streaming
      resetDut();
      checkOutput("rst_req", {31'h0, imem_req}, 32'd0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_valid", {31'h0, out_valid}, 32'd0);
      checkOutput("rst_pc", out_pc, 32'h0);
      checkOutput("rst_instr", out_instr, 32'h0);
      for (int i = 0; i < 8; i++)
         expectWord(32'(4 * i));
      applyStimulus(1'b1, 1'b0, 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("t1_req", {31'h0, imem_req}, 32'd1);
      checkOutput("t1_addr0", imem_addr, 32'h0);
      checkOutput("t1_valid_early", {31'h0, out_valid}, 32'd0);
      tick();
      checkOutput("t1_valid", {31'h0, out_valid}, 32'd1);
      checkOutput("t1_first_pc", out_pc, 32'h0);
      checkOutput("t1_addr4", imem_addr, 32'h4);
      for (int j = 3; j <= 4; j++) begin
         tick();
         checkOutput("t1_stream_pc", out_pc, 32'(4 * (j - 2)));
         checkOutput("t1_stream_addr", imem_addr, 32'(4 * (j - 1)));
      end
      drainQueue("t1_drain");

      // Backpressure: DEPTH words buffered, then fetch stops
      resetDut();
      expectWord(32'h0);
      expectWord(32'h4);
      expectWord(32'h8);
      expectWord(32'hC);
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("t2_req_second", {31'h0, imem_req}, 32'd1);
      tick();
      checkOutput("t2_req_stopped", {31'h0, imem_req}, 32'd0);
      checkOutput("t2_head_pc", out_pc, 32'h0);
      tick();
      tick();
      tick();
      checkOutput("t2_still_stopped", {31'h0, imem_req}, 32'd0);
      checkOutput("t2_head_hold_pc", out_pc, 32'h0);
      checkOutput("t2_head_hold_instr", out_instr, mem_word(32'h0));
      out_ready = 1'b1;
      tick();
      tick();
      checkOutput("t2_resume_req", {31'h0, imem_req}, 32'd1);
      checkOutput("t2_resume_addr", imem_addr, 32'h8);
      drainQueue("t2_drain");

      // Redirect while a delayed request is outstanding
      resetDut();
      ack_delay = 3;
      rst_n = 1'b1;
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 32'h0000_0103);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t3_held_req", {31'h0, imem_req}, 32'd1);
      checkOutput("t3_held_addr", imem_addr, 32'h0);
      tick();
      tick();
      checkOutput("t3_dropped_valid", {31'h0, out_valid}, 32'd0);
      for (int i = 0; i < 20 && !(imem_req && imem_addr != 32'h0); i++)
         tick();
      checkOutput("t3_new_addr", imem_addr, 32'h0000_0100);
      expectWord(32'h0000_0100);
      expectWord(32'h0000_0104);
      drainQueue("t3_drain");
      ack_delay = 0;

      // Redirect coincident with ack and head handshake
      resetDut();
      expectWord(32'h0);
      expectWord(32'h4);
      expectWord(32'h8);
      expectWord(32'h40);
      expectWord(32'h44);
      applyStimulus(1'b1, 1'b0, 32'h0);
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      tick();
      checkOutput("t4_ack_cycle", {31'h0, imem_ack}, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h0000_0040);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t4_flushed_valid", {31'h0, out_valid}, 32'd0);
      checkOutput("t4_idle_req", {31'h0, imem_req}, 32'd0);
      tick();
      checkOutput("t4_target_addr", imem_addr, 32'h0000_0040);
      drainQueue("t4_drain");

      // Redirect near the top of the address space, PC wraps
      resetDut();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      expectWord(32'hFFFF_FFF8);
      expectWord(32'hFFFF_FFFC);
      expectWord(32'h0000_0000);
      expectWord(32'h0000_0004);
      drainQueue("t5_drain");

      // Field decode, then reset in the middle of a burst
      resetDut();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 32'h0000_0200);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 20 && !out_valid; i++)
         tick();
      checkOutput("t6_pc", out_pc, 32'h0000_0200);
      checkOutput("t6_instr", out_instr, 32'h3C01_8001);
      checkOutput("t6_op", {26'h0, out_op}, 32'h0F);
      checkOutput("t6_rs", {27'h0, out_rs}, 32'h00);
      checkOutput("t6_rt", {27'h0, out_rt}, 32'h01);
      checkOutput("t6_rd", {27'h0, out_rd}, 32'h10);
      checkOutput("t6_shamt", {27'h0, out_shamt}, 32'h00);
      checkOutput("t6_funct", {26'h0, out_funct}, 32'h01);
      checkOutput("t6_imm16", {16'h0, out_imm16}, 32'h8001);
      checkOutput("t6_jidx", {6'h0, out_jidx}, 32'h0018001);
      checkOutput("t6_busy_req", {31'h0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_req", {31'h0, imem_req}, 32'd0);
      checkOutput("t6_async_addr", imem_addr, 32'h0);
      checkOutput("t6_async_valid", {31'h0, out_valid}, 32'd0);
      checkOutput("t6_async_instr", out_instr, 32'h0);
      checkOutput("t6_async_jidx", {6'h0, out_jidx}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
